// File: rtl/car_park_gate_ctrl.sv
// Car-park gate controller: keypad password check, occupancy counting,
// FULL handling, wrong-password lockout and idle timeout on password entry.
//
// Keypad handshake: pass_valid is a one-cycle strobe with no ready/back-pressure.
// USER/PASSWORD are sampled only on an edge where pass_valid is high, and the
// controller always consumes the strobe on that edge. In states that do not wait
// for a password (IDLE, FULL, RIGHT_PASS, LOCKOUT) the strobe is dropped.
module car_park_gate_ctrl #(
   parameter int CAPACITY    = 7,
   parameter int W_PASS      = 4,
   parameter int KEY_OFFSET  = 2,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT     = 16,
   parameter int LOCK_CYCLES = 32,
   localparam int W_CNT      = $clog2(CAPACITY + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              entrance_front,
   input  logic              entrance_back,
   input  logic              exit,
   input  logic              pass_valid,
   input  logic [W_PASS-1:0] USER,
   input  logic [W_PASS-1:0] PASSWORD,
   output logic              LED_RED,
   output logic              LED_GREEN,
   output logic [2:0]        STATE,
   output logic [W_CNT-1:0]  SPOTS_AVAILABLE
);

   localparam int W_TRY  = $clog2(MAX_TRIES + 1);
   localparam int W_IDLE = $clog2(TIMEOUT + 1);
   localparam int W_LOCK = $clog2(LOCK_CYCLES + 1);

   localparam logic [W_CNT-1:0]  CAP_C     = W_CNT'(CAPACITY);
   localparam logic [W_TRY-1:0]  TRY_MAX   = W_TRY'(MAX_TRIES);
   localparam logic [W_IDLE-1:0] IDLE_LAST = W_IDLE'(TIMEOUT - 1);
   localparam logic [W_LOCK-1:0] LOCK_LAST = W_LOCK'(LOCK_CYCLES - 1);
   localparam logic [W_PASS-1:0] KEY_OFS   = W_PASS'(KEY_OFFSET);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_PASS  = 3'd1,
      S_RIGHT_PASS = 3'd2,
      S_WRONG_PASS = 3'd3,
      S_STOP       = 3'd4,
      S_FULL       = 3'd5,
      S_LOCKOUT    = 3'd6
   } state_t;

   state_t              state, state_d;
   logic [W_CNT-1:0]    count, count_d;
   logic [W_TRY-1:0]    tries, tries_d, tries_inc;
   logic [W_IDLE-1:0]   idle_tmr, idle_d;
   logic [W_LOCK-1:0]   lock_tmr, lock_d;
   logic                full, in_wait, key_ok, correct, wrong, inc_req, dec;

   assign full      = (count == CAP_C);
   assign in_wait   = (state == S_WAIT_PASS) || (state == S_WRONG_PASS) || (state == S_STOP);
   assign key_ok    = (PASSWORD == USER + KEY_OFS);
   assign correct   = pass_valid && key_ok;
   assign wrong     = pass_valid && !key_ok;
   assign tries_inc = tries + 1'b1;
   // A car clearing the gate from RIGHT_PASS asks for a spot; an exit frees one.
   assign inc_req   = (state == S_RIGHT_PASS) && entrance_back;
   assign dec       = exit && (count != '0);

   // Occupancy update: simultaneous entry and exit cancel, entry saturates at capacity.
   always_comb begin
      count_d = count;
      if (inc_req && dec) begin
         count_d = count;
      end else if (inc_req) begin
         if (!full) count_d = count + 1'b1;
      end else if (dec) begin
         count_d = count - 1'b1;
      end
   end

   // Next-state logic plus try, idle-timer and lockout-timer updates.
   always_comb begin
      state_d = state;
      tries_d = tries;
      lock_d  = '0;
      // The idle timer runs only inside password-wait states; a strobe restarts it.
      idle_d  = (in_wait && !pass_valid) ? idle_tmr + 1'b1 : '0;
      case (state)
         S_IDLE: begin
            if (entrance_front) state_d = full ? S_FULL : S_WAIT_PASS;
         end
         S_FULL: begin
            if (!entrance_front) state_d = S_IDLE;
            else if (!full)      state_d = S_WAIT_PASS;
         end
         S_WAIT_PASS, S_WRONG_PASS, S_STOP: begin
            if (correct) begin
               state_d = S_RIGHT_PASS;
               tries_d = '0;
            end else if (wrong) begin
               tries_d = tries_inc;
               state_d = (tries_inc == TRY_MAX) ? S_LOCKOUT : S_WRONG_PASS;
            end else if (idle_tmr == IDLE_LAST) begin
               state_d = S_IDLE;
               tries_d = '0;
            end
         end
         S_RIGHT_PASS: begin
            if (entrance_back) begin
               if (!entrance_front)      state_d = S_IDLE;
               else if (count_d < CAP_C) state_d = S_STOP;
               else                      state_d = S_FULL;
            end
         end
         S_LOCKOUT: begin
            if (lock_tmr == LOCK_LAST) begin
               state_d = S_IDLE;
               tries_d = '0;
            end else begin
               lock_d = lock_tmr + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tries_d = '0;
         end
      endcase
   end

   // State, occupancy, tries and timers; reset discards any entry in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         count    <= '0;
         tries    <= '0;
         idle_tmr <= '0;
         lock_tmr <= '0;
      end else begin
         state    <= state_d;
         count    <= count_d;
         tries    <= tries_d;
         idle_tmr <= idle_d;
         lock_tmr <= lock_d;
      end
   end

   assign STATE           = state;
   assign SPOTS_AVAILABLE = CAP_C - count;
   assign LED_GREEN       = (state == S_RIGHT_PASS);
   assign LED_RED         = (state == S_WRONG_PASS) || (state == S_STOP) ||
                            (state == S_FULL) || (state == S_LOCKOUT);

endmodule

// File: tb/tb_car_park_gate_ctrl.sv
// Bench for car_park_gate_ctrl: a vector table for the main entry flows plus
// hand-written sequences for timeout, lockout, FULL and reset corner cases.
module tb_car_park_gate_ctrl;

   localparam int CAPACITY = 7;
   localparam int W_PASS   = 4;
   localparam int W_CNT    = 3;
   localparam int W_EXP    = 3 + W_CNT + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              entrance_front = 1'b0;
   logic              entrance_back  = 1'b0;
   logic              exit           = 1'b0;
   logic              pass_valid     = 1'b0;
   logic [W_PASS-1:0] user_id  = '0;
   logic [W_PASS-1:0] password = '0;
   logic              led_red, led_green;
   logic [2:0]        state;
   logic [W_CNT-1:0]  spots;

   int n_vec = 0;
   int n_bad = 0;
   logic [W_EXP-1:0] exp_q[$];

   typedef struct {
      logic             ef, eb, ex, pv;
      logic [3:0]       u, p;
      logic [2:0]       st;
      logic [W_CNT-1:0] sp;
   } vec_t;
   vec_t vecs[$];

   // Clock
   always #5 clk = ~clk;

   car_park_gate_ctrl #(
      .CAPACITY(CAPACITY), .W_PASS(W_PASS), .KEY_OFFSET(2),
      .MAX_TRIES(3), .TIMEOUT(16), .LOCK_CYCLES(32)
   ) dut (
      .clk(clk), .rst(rst),
      .entrance_front(entrance_front), .entrance_back(entrance_back),
      .exit(exit), .pass_valid(pass_valid),
      .USER(user_id), .PASSWORD(password),
      .LED_RED(led_red), .LED_GREEN(led_green),
      .STATE(state), .SPOTS_AVAILABLE(spots)
   );

   // Expected LEDs follow directly from the expected state code.
   function automatic logic [W_EXP-1:0] pack_exp(logic [2:0] st, logic [W_CNT-1:0] sp);
      logic red, green;
      red   = (st == 3'd3) || (st == 3'd4) || (st == 3'd5) || (st == 3'd6);
      green = (st == 3'd2);
      return {st, sp, red, green};
   endfunction

   task automatic add(logic ef, logic eb, logic ex, logic pv, logic [3:0] u, logic [3:0] p,
                      logic [2:0] st, logic [W_CNT-1:0] sp);
      vec_t v;
      v.ef = ef; v.eb = eb; v.ex = ex; v.pv = pv;
      v.u = u; v.p = p; v.st = st; v.sp = sp;
      vecs.push_back(v);
   endtask

   // Scoreboard: pop the oldest expectation and compare with the DUT outputs.
   task automatic check(string name);
      logic [W_EXP-1:0] exp_v, got;
      n_vec++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: scoreboard empty", name);
         n_bad++;
         return;
      end
      exp_v = exp_q.pop_front();
      got   = {state, spots, led_red, led_green};
      if (got !== exp_v) begin
         $display("FAIL %s: got state=%0d spots=%0d red=%0b green=%0b, expected state=%0d spots=%0d red=%0b green=%0b",
                  name, got[W_EXP-1 -: 3], got[W_CNT+1:2], got[1], got[0],
                  exp_v[W_EXP-1 -: 3], exp_v[W_CNT+1:2], exp_v[1], exp_v[0]);
         n_bad++;
      end
   endtask

   // Driver: inputs change on the falling edge, outputs checked 1 time unit after the rising edge.
   task automatic step(string name, logic ef, logic eb, logic ex, logic pv,
                       logic [3:0] u, logic [3:0] p, logic [2:0] st, logic [W_CNT-1:0] sp);
      @(negedge clk);
      entrance_front = ef; entrance_back = eb; exit = ex; pass_valid = pv;
      user_id = u; password = p;
      exp_q.push_back(pack_exp(st, sp));
      @(posedge clk);
      #1;
      check(name);
   endtask

   task automatic idle_in(string name, logic [2:0] st, logic [W_CNT-1:0] sp);
      step(name, 0, 0, 0, 0, 4'd0, 4'd0, st, sp);
   endtask

   task automatic enter_car(logic [W_CNT-1:0] sp_before, logic [W_CNT-1:0] sp_after);
      step("fill_front", 1, 0, 0, 0, 4'd0, 4'd0, 3'd1, sp_before);
      step("fill_pass",  0, 0, 0, 1, 4'd3, 4'd5, 3'd2, sp_before);
      step("fill_back",  0, 1, 0, 0, 4'd0, 4'd0, 3'd0, sp_after);
   endtask

   task automatic async_reset(string name);
      #2;
      rst = 1'b0;
      #1;
      exp_q.push_back(pack_exp(3'd0, W_CNT'(CAPACITY)));
      check(name);
      @(negedge clk);
      entrance_front = 0; entrance_back = 0; exit = 0; pass_valid = 0;
      rst = 1'b1;
   endtask

   initial begin
      // Main flows: ef, eb, ex, pv, USER, PASSWORD -> STATE, SPOTS_AVAILABLE
      add(1,0,0,0, 4'd0, 4'd0,  3'd1, 3'd7);  // car at front
      add(1,0,0,1, 4'd3, 4'd5,  3'd2, 3'd7);  // correct key, green next edge
      add(0,1,0,0, 4'd0, 4'd0,  3'd0, 3'd6);  // car through
      add(1,0,0,0, 4'd0, 4'd0,  3'd1, 3'd6);
      add(0,0,0,1, 4'd3, 4'd2,  3'd3, 3'd6);  // wrong
      add(0,0,0,1, 4'd3, 4'd3,  3'd3, 3'd6);  // wrong again
      add(0,0,0,1, 4'd3, 4'd5,  3'd2, 3'd6);  // correct clears tries
      add(0,1,0,0, 4'd0, 4'd0,  3'd0, 3'd5);
      add(1,0,0,0, 4'd0, 4'd0,  3'd1, 3'd5);
      add(0,0,0,1, 4'd3, 4'd0,  3'd3, 3'd5);  // two more wrongs: no lockout if cleared
      add(0,0,0,1, 4'd3, 4'd0,  3'd3, 3'd5);
      add(0,0,0,1, 4'd3, 4'd5,  3'd2, 3'd5);
      add(1,1,0,0, 4'd0, 4'd0,  3'd4, 3'd4);  // tailgater -> STOP
      add(1,0,0,1, 4'd3, 4'd5,  3'd2, 3'd4);  // correct from STOP
      add(0,1,0,0, 4'd0, 4'd0,  3'd0, 3'd3);
      add(0,0,1,0, 4'd0, 4'd0,  3'd0, 3'd4);  // exit frees a spot
      add(1,0,0,0, 4'd0, 4'd0,  3'd1, 3'd4);
      add(0,0,0,1, 4'd9, 4'd10, 3'd3, 3'd4);  // off-by-one key is wrong
      add(0,0,0,1, 4'd15,4'd1,  3'd2, 3'd4);  // key wraps mod 16
      add(0,1,1,0, 4'd0, 4'd0,  3'd0, 3'd4);  // entry + exit same edge
      add(1,0,0,0, 4'd0, 4'd0,  3'd1, 3'd4);
      add(0,0,0,1, 4'd9, 4'd11, 3'd2, 3'd4);
      add(0,0,0,0, 4'd0, 4'd0,  3'd2, 3'd4);  // RIGHT_PASS holds
      add(0,1,0,0, 4'd0, 4'd0,  3'd0, 3'd3);
      add(0,0,1,0, 4'd0, 4'd0,  3'd0, 3'd4);

      // Reset block
      #12;
      exp_q.push_back(pack_exp(3'd0, W_CNT'(CAPACITY)));
      check("reset");
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i].ef, vecs[i].eb, vecs[i].ex, vecs[i].pv,
              vecs[i].u, vecs[i].p, vecs[i].st, vecs[i].sp);

      // Timeout: back in IDLE exactly 16 edges after entering WAIT_PASS.
      step("to_enter", 1, 0, 0, 0, 4'd0, 4'd0, 3'd1, 3'd4);
      for (int i = 1; i <= 16; i++)
         idle_in($sformatf("to_wait%0d", i), (i == 16) ? 3'd0 : 3'd1, 3'd4);

      // A strobe restarts the idle timer; timeout also clears tries.
      step("to2_enter", 1, 0, 0, 0, 4'd0, 4'd0, 3'd1, 3'd4);
      for (int i = 1; i <= 10; i++) idle_in("to2_pre", 3'd1, 3'd4);
      step("to2_wrong", 0, 0, 0, 1, 4'd3, 4'd0, 3'd3, 3'd4);
      for (int i = 1; i <= 16; i++)
         idle_in($sformatf("to2_wait%0d", i), (i == 16) ? 3'd0 : 3'd3, 3'd4);

      // Lockout: three wrongs, 32 edges locked, strobes and sensors ignored.
      step("lk_enter", 1, 0, 0, 0, 4'd0, 4'd0, 3'd1, 3'd4);
      step("lk_w1",    0, 0, 0, 1, 4'd3, 4'd0, 3'd3, 3'd4);
      step("lk_w2",    0, 0, 0, 1, 4'd3, 4'd0, 3'd3, 3'd4);
      step("lk_w3",    0, 0, 0, 1, 4'd3, 4'd0, 3'd6, 3'd4);
      for (int i = 1; i <= 32; i++) begin
         if (i == 5)
            step("lk_ignore", 1, 1, 0, 1, 4'd3, 4'd5, 3'd6, 3'd4);
         else
            idle_in($sformatf("lk_cyc%0d", i), (i == 32) ? 3'd0 : 3'd6, 3'd4);
      end
      step("lk_after",  1, 0, 0, 0, 4'd0, 4'd0, 3'd1, 3'd4);
      step("lk_wrong",  0, 0, 0, 1, 4'd3, 4'd7, 3'd3, 3'd4);
      step("lk_right",  0, 0, 0, 1, 4'd3, 4'd5, 3'd2, 3'd4);
      step("lk_back",   0, 1, 0, 0, 4'd0, 4'd0, 3'd0, 3'd3);

      // Fill to capacity, FULL, exit, and tailgate into FULL.
      enter_car(3'd3, 3'd2);
      enter_car(3'd2, 3'd1);
      enter_car(3'd1, 3'd0);
      step("full_front", 1, 0, 0, 0, 4'd0, 4'd0, 3'd5, 3'd0);
      step("full_hold",  1, 0, 0, 1, 4'd3, 4'd5, 3'd5, 3'd0);
      step("full_exit",  1, 0, 1, 0, 4'd0, 4'd0, 3'd5, 3'd1);
      step("full_wait",  1, 0, 0, 0, 4'd0, 4'd0, 3'd1, 3'd1);
      step("full_pass",  1, 0, 0, 1, 4'd3, 4'd5, 3'd2, 3'd1);
      step("tail_full",  1, 1, 0, 0, 4'd0, 4'd0, 3'd5, 3'd0);
      step("full_leave", 0, 0, 0, 0, 4'd0, 4'd0, 3'd0, 3'd0);

      // Mid-operation reset clears occupancy; exit at zero is ignored.
      step("mid_exit",  0, 0, 1, 0, 4'd0, 4'd0, 3'd0, 3'd1);
      step("mid_front", 1, 0, 0, 0, 4'd0, 4'd0, 3'd1, 3'd1);
      async_reset("reset_mid");
      step("exit_zero", 0, 0, 1, 0, 4'd0, 4'd0, 3'd0, 3'd7);
      step("post_front",1, 0, 0, 0, 4'd0, 4'd0, 3'd1, 3'd7);
      step("post_pass", 0, 0, 0, 1, 4'd3, 4'd5, 3'd2, 3'd7);

      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
         n_bad++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/car_park_gate_ctrl.md
# car_park_gate_ctrl

Parametrised car-park gate controller. It extends the single-gate password FSM with a configurable capacity and occupancy counter, a FULL state, a wrong-password retry limit with timed lockout, an idle timeout, and an exit path that frees spots. It sits between the gate sensors and keypad on one side and the gate LEDs and occupancy display on the other.

## Interface
- `CAPACITY`, 7: number of parking spots (1..255).
- `W_PASS`, 4: width of `USER` and `PASSWORD`.
- `KEY_OFFSET`, 2: a password is correct when `PASSWORD == (USER + KEY_OFFSET) mod 2^W_PASS`.
- `MAX_TRIES`, 3: number of wrong attempts that triggers lockout.
- `TIMEOUT`, 16: idle cycles allowed in password-wait states before abandoning.
- `LOCK_CYCLES`, 32: duration of lockout in cycles.
- `W_CNT`: localparam, `$clog2(CAPACITY+1)`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `entrance_front`, input, 1: car present at the entry sensor.
- `entrance_back`, input, 1: car has passed the gate.
- `exit`, input, 1: one-cycle pulse when a car leaves.
- `pass_valid`, input, 1: one-cycle strobe; `USER`/`PASSWORD` are valid this cycle.
- `USER`, input, W_PASS: user ID.
- `PASSWORD`, input, W_PASS: entered password.
- `LED_RED`, output, 1: gate closed / warning.
- `LED_GREEN`, output, 1: gate open.
- `STATE`, output, 3: current state code.
- `SPOTS_AVAILABLE`, output, W_CNT: `CAPACITY - count`.

## Operation
- State codes: IDLE=0, WAIT_PASS=1, RIGHT_PASS=2, WRONG_PASS=3, STOP=4, FULL=5, LOCKOUT=6. Code 7 is illegal and recovers to IDLE.
- "full" means `count == CAPACITY`. "correct" means `pass_valid` is high and the key matches. "wrong" means `pass_valid` is high and the key does not match.
- **IDLE:**
  - `entrance_front` and not full → WAIT_PASS.
  - `entrance_front` and full → FULL.
- **FULL:**
  - `entrance_front` low → IDLE.
  - Not full (an exit occurred) and `entrance_front` high → WAIT_PASS.
- **WAIT_PASS, WRONG_PASS, STOP** (password-wait states):
  - correct → RIGHT_PASS; clear `tries`.
  - wrong → increment `tries`; if the new `tries` equals MAX_TRIES → LOCKOUT, else → WRONG_PASS.
  - Idle timer reaches TIMEOUT → IDLE; clear `tries`.
- **Idle timer:** resets on entry to any password-wait state and on every `pass_valid`. Otherwise it increments each cycle.
- **RIGHT_PASS:**
  - `entrance_back` and not `entrance_front` → IDLE; count +1.
  - `entrance_back` and `entrance_front` (tailgater) → count +1, then: STOP if the new count is below CAPACITY, FULL otherwise.
  - Remains in RIGHT_PASS indefinitely otherwise (no timeout).
- **LOCKOUT:**
  - Counts LOCK_CYCLES cycles, then → IDLE with `tries` cleared.
  - `pass_valid` and `entrance_*` are ignored.
- **Exit:** `exit` with count>0 decrements count in any state. `exit` at count 0 is ignored.
- **Simultaneous exit and entry increment** in the same cycle: count is unchanged.
- **Count saturation:** count never exceeds CAPACITY; an increment request at full is dropped.
- **Outputs (Moore, decoded from the state register):**
  - `LED_GREEN` = 1 in RIGHT_PASS.
  - `LED_RED` = 1 in WRONG_PASS, STOP, FULL and LOCKOUT.
  - Both LEDs are 0 in IDLE and WAIT_PASS.

## Timing
- All inputs are sampled on the rising edge of `clk`. A state change and its outputs are visible after the same edge.
- Reset (`rst` low, asynchronous), in effect immediately:
  - STATE=0, count=0, SPOTS_AVAILABLE=CAPACITY.
  - LED_RED=0, LED_GREEN=0.
  - tries=0, idle timer=0, lock timer=0.
- Reset asserted mid-operation discards the in-progress entry. Occupancy is cleared to 0 by design.
- Latency from a correct `pass_valid` to LED_GREEN=1 is 1 edge.
- TIMEOUT: with no `pass_valid`, the FSM is back in IDLE exactly TIMEOUT edges after entering a wait state.
- LOCKOUT lasts exactly LOCK_CYCLES edges, then the FSM is in IDLE.
- SPOTS_AVAILABLE updates on the same edge as the count change.

## Test plan
- **Reset then entry:** reset, then `entrance_front`=1, then `pass_valid` with USER=3, PASSWORD=5, then `entrance_back` pulse.
  - Required STATE sequence: 1, 2, 0; SPOTS_AVAILABLE goes 7 → 6; LED_GREEN high only in state 2.
- **Wrong then correct:** PASSWORD=2 (→3, RED), then 3 (→3), then 5 (→2).
  - Required: tries cleared, and a subsequent entry is allowed.
- **Lockout:** three wrong passwords.
  - Required: STATE=6 and LED_RED=1 for 32 cycles; `pass_valid` with PASSWORD=5 during lockout is ignored; then STATE=0.
- **Fill and exit:** fill 7 cars → SPOTS_AVAILABLE=0.
  - An 8th `entrance_front` → STATE=5.
  - `exit` pulse → SPOTS_AVAILABLE=1 and STATE=1.
- **Tailgate:** in RIGHT_PASS, `entrance_back`=1 and `entrance_front`=1 together.
  - Required: STATE=4, count +1; a correct password → STATE=2.
- **Timeout and boundary:**
  - In WAIT_PASS with no `pass_valid` for 16 cycles → STATE=0.
  - `exit` at count 0 → SPOTS_AVAILABLE stays 7.
  - `exit` coincident with an entry increment → count unchanged.
